digit_renderer: RTL

- Pixel-side consumer and address generator for the digit font ROM in the VGA clock display path.
- Receives the VGA timing generator's pixel coordinates and a packed BCD time string, and computes the glyph row address for the font ROM.
- Takes the ROM's registered 4-bit row data back and emits a per-pixel "lit" flag, scaled in square blocks, with fixed latency.
- Sits between the VGA timing generator/time counter and the colour mux that drives the RGB pins.

---
 rtl/digit_renderer_pkg.sv | 16 +
 rtl/digit_renderer_if.sv | 13 +
 rtl/digit_renderer_hcount.sv | 83 ++++++++
 rtl/digit_renderer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/digit_renderer_pkg.sv
// Shared constants for the digit font rendering path: glyph geometry defaults,
// BCD blanking threshold and the pixel pipeline latency used by the colour mux.
package digit_renderer_pkg;

  localparam int         GLYPH_W_DEF    = 4;
  localparam int         GLYPH_H_DEF    = 5;
  localparam int         SCALE_LOG2_DEF = 4;
  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam int         RENDER_LAT     = 3;

  // Nibbles above 9 are not decimal digits and render as blank cells.
  function automatic logic bcd_renderable(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/digit_renderer_if.sv
// Font ROM bus between the digit renderer (master) and the glyph ROM (slave).
interface digit_renderer_if #(
  parameter int ADDR_W  = 6,
  parameter int GLYPH_W = 4
);

  logic [ADDR_W-1:0]  font_addr;
  logic [GLYPH_W-1:0] font_dout;

  modport master (output font_addr, input font_dout);
  modport slave  (input font_addr, output font_dout);

endinterface

// File: rtl/digit_renderer_hcount.sv
// Horizontal position tracker: block sub-pixel, glyph column (incl. gap) and digit
// index for the pixel currently on x_px, re-armed at x_px == X0.
module digit_renderer_hcount
  import digit_renderer_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
  parameter int GLYPH_W    = GLYPH_W_DEF,
  parameter int X0         = 64,
  parameter int COL_W      = $clog2(GLYPH_W + 1),
  parameter int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       x_px,
  input  logic             active,
  output logic [COL_W-1:0] col,
  output logic [DIG_W-1:0] dig,
  output logic             in_band
);

  localparam logic [SCALE_LOG2-1:0] SUB_MAX  = {SCALE_LOG2{1'b1}};
  localparam logic [COL_W-1:0]      COL_GAP  = COL_W'(GLYPH_W);
  localparam logic [DIG_W-1:0]      DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [SCALE_LOG2-1:0] sub_r, sub_s;
  logic [COL_W-1:0]      col_r, col_s;
  logic [DIG_W-1:0]      dig_r, dig_s;
  logic                  in_band_r, in_band_s;

  // Position of the current pixel, derived from the previous pixel's state.
  always_comb begin
    sub_s     = {SCALE_LOG2{1'b0}};
    col_s     = {COL_W{1'b0}};
    dig_s     = {DIG_W{1'b0}};
    in_band_s = 1'b0;
    if (active && (x_px == 10'(X0))) begin
      in_band_s = 1'b1;
    end else if (active && in_band_r) begin
      in_band_s = 1'b1;
      sub_s     = sub_r + SCALE_LOG2'(1);
      col_s     = col_r;
      dig_s     = dig_r;
      if (sub_r == SUB_MAX) begin
        if (col_r == COL_GAP) begin
          col_s = {COL_W{1'b0}};
          if (dig_r == DIG_LAST) begin
            in_band_s = 1'b0;
            dig_s     = {DIG_W{1'b0}};
          end else begin
            dig_s = dig_r + DIG_W'(1);
          end
        end else begin
          col_s = col_r + COL_W'(1);
        end
      end else begin
        col_s = col_r;
      end
    end else begin
      in_band_s = 1'b0;
    end
  end

  // Remember this pixel's position as the base for the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_r     <= {SCALE_LOG2{1'b0}};
      col_r     <= {COL_W{1'b0}};
      dig_r     <= {DIG_W{1'b0}};
      in_band_r <= 1'b0;
    end else begin
      sub_r     <= sub_s;
      col_r     <= col_s;
      dig_r     <= dig_s;
      in_band_r <= in_band_s;
    end
  end

  assign col     = col_s;
  assign dig     = dig_s;
  assign in_band = in_band_s;

endmodule

// File: rtl/digit_renderer.sv
// Renders a frame-latched BCD time string as block-scaled glyphs: drives the font
// ROM address and produces a per-pixel lit flag a fixed RENDER_LAT clocks later.
module digit_renderer
  import digit_renderer_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
  parameter int X0         = 64,
  parameter int Y0         = 200,
  parameter int GLYPH_W    = GLYPH_W_DEF,
  parameter int GLYPH_H    = GLYPH_H_DEF,
  parameter int ADDR_W     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              x_px,
  input  logic [9:0]              y_px,
  input  logic                    active,
  input  logic                    frame_start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  digit_renderer_if.master        rom,
  output logic                    pixel_on,
  output logic                    pixel_valid
);

  localparam int COL_W = $clog2(GLYPH_W + 1);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SEL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int AW1   = ADDR_W + 1;

  logic [4*NUM_DIGITS-1:0] snap_r;
  logic [COL_W-1:0]        col_s;
  logic [DIG_W-1:0]        dig_s;
  logic                    in_band_s;
  logic [9:0]              rel_y_s;
  logic [9:0]              row_s;
  logic                    v_ok_s;
  logic [3:0]              cur_digit_s;
  logic                    lit_en_s;
  logic [ADDR_W-1:0]       addr_s;
  logic [ADDR_W-1:0]       font_addr_r;
  logic                    lit_en_r, lit_en_d_r;
  logic [COL_W-1:0]        colsel_r, colsel_d_r;
  logic                    active_d1_r, active_d2_r;
  logic [SEL_W-1:0]        sel_idx_s;
  logic                    pixel_on_r, pixel_valid_r;

  // Latch the time string once per frame so a glyph never changes mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_r <= {(4*NUM_DIGITS){1'b0}};
    end else if (frame_start) begin
      snap_r <= digits;
    end else begin
      snap_r <= snap_r;
    end
  end

  digit_renderer_hcount #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCALE_LOG2 (SCALE_LOG2),
    .GLYPH_W    (GLYPH_W),
    .X0         (X0),
    .COL_W      (COL_W),
    .DIG_W      (DIG_W)
  ) u_hcount (
    .clk     (clk),
    .reset   (reset),
    .x_px    (x_px),
    .active  (active),
    .col     (col_s),
    .dig     (dig_s),
    .in_band (in_band_s)
  );

  // The compare on y_px guards against rel_y wrapping above the band.
  assign rel_y_s = y_px - 10'(Y0);
  assign row_s   = rel_y_s >> SCALE_LOG2;
  assign v_ok_s  = (y_px >= 10'(Y0)) && (row_s < 10'(GLYPH_H));

  // Pick the nibble of the digit under the beam; digit 0 sits in the MSBs.
  always_comb begin
    cur_digit_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_s == DIG_W'(i)) begin
        cur_digit_s = snap_r[4*(NUM_DIGITS-1-i) +: 4];
      end else begin
        cur_digit_s = cur_digit_s;
      end
    end
  end

  assign lit_en_s = in_band_s && v_ok_s && (col_s < COL_W'(GLYPH_W)) &&
                    bcd_renderable(cur_digit_s);
  assign addr_s   = ADDR_W'(AW1'(cur_digit_s) * AW1'(GLYPH_H) + AW1'(row_s));

  // Stage 1: ROM address plus the per-pixel qualifiers that travel with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      font_addr_r <= {ADDR_W{1'b0}};
      lit_en_r    <= 1'b0;
      colsel_r    <= {COL_W{1'b0}};
      active_d1_r <= 1'b0;
    end else begin
      font_addr_r <= lit_en_s ? addr_s : {ADDR_W{1'b0}};
      lit_en_r    <= lit_en_s;
      colsel_r    <= col_s;
      active_d1_r <= active;
    end
  end

  assign rom.font_addr = font_addr_r;

  // Stage 2: qualifiers wait while the ROM registers the row data.
  always_ff @(posedge clk) begin
    if (reset) begin
      lit_en_d_r  <= 1'b0;
      colsel_d_r  <= {COL_W{1'b0}};
      active_d2_r <= 1'b0;
    end else begin
      lit_en_d_r  <= lit_en_r;
      colsel_d_r  <= colsel_r;
      active_d2_r <= active_d1_r;
    end
  end

  // Column 0 is the ROM MSB; gap columns never reach here with lit_en set.
  assign sel_idx_s = SEL_W'(GLYPH_W - 1) - SEL_W'(colsel_d_r);

  // Stage 3: final lit flag aligned with the delayed active.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_on_r    <= 1'b0;
      pixel_valid_r <= 1'b0;
    end else begin
      pixel_on_r    <= lit_en_d_r && rom.font_dout[sel_idx_s];
      pixel_valid_r <= active_d2_r;
    end
  end

  assign pixel_on    = pixel_on_r;
  assign pixel_valid = pixel_valid_r;

endmodule
